// File: rtl/pipelined_multiplier.sv
// Unsigned DATA_LEN x DATA_LEN multiplier returning the low DATA_LEN bits of
// the product. The multiplier b is cut into PIPELINE_STAGE slices; each stage
// adds one shifted partial product to a running accumulator. Stage 0 is purely
// combinational from the inputs, every later stage ends in a register, so the
// register latency is PIPELINE_STAGE-1. There is no handshake: a new operand
// pair is accepted every cycle and result is simply sampled after the latency.
module pipelined_multiplier #(
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic [DATA_LEN-1:0] result
);

   // Slice width rounds up, so the last slice may be narrower or even empty;
   // an empty slice shifts its partial product entirely out of the result.
   localparam int SLICE_W  = (DATA_LEN + PIPELINE_STAGE - 1) / PIPELINE_STAGE;
   localparam int NUM_REGS = PIPELINE_STAGE - 1;

   function automatic logic [DATA_LEN-1:0] low_mask();
      logic [DATA_LEN-1:0] m;
      for (int i = 0; i < DATA_LEN; i++) begin
         m[i] = (i < SLICE_W);
      end
      return m;
   endfunction

   localparam logic [DATA_LEN-1:0] SLICE_MASK = low_mask();

   logic [DATA_LEN-1:0] acc0;

   // Stage 0: partial product of a with the lowest slice of b.
   always_comb begin
      acc0 = a * (b & SLICE_MASK);
   end

   if (NUM_REGS == 0) begin : g_comb
      assign result = acc0;
   end else begin : g_pipe
      // Slices of b not consumed yet, aligned so the next slice sits at bit 0.
      logic [DATA_LEN-1:0] brem0;
      assign brem0 = b >> SLICE_W;

      for (genvar k = 1; k <= NUM_REGS; k++) begin : g_stage
         logic [DATA_LEN-1:0] acc_in;
         logic [DATA_LEN-1:0] a_in;
         logic [DATA_LEN-1:0] brem_in;
         logic [DATA_LEN-1:0] acc_q;

         if (k == 1) begin : g_src
            assign acc_in  = acc0;
            assign a_in    = a;
            assign brem_in = brem0;
         end else begin : g_src
            assign acc_in  = g_stage[k-1].acc_q;
            assign a_in    = g_stage[k-1].g_fwd.a_q;
            assign brem_in = g_stage[k-1].g_fwd.brem_q;
         end

         // Accumulate slice k of b, weighted by its bit position.
         always_ff @(posedge clk) begin
            if (!reset) begin
               acc_q <= '0;
            end else begin
               acc_q <= acc_in + ((a_in * (brem_in & SLICE_MASK)) << (k * SLICE_W));
            end
         end

         // The operands only travel on while a later stage still needs them.
         if (k < NUM_REGS) begin : g_fwd
            logic [DATA_LEN-1:0] a_q;
            logic [DATA_LEN-1:0] brem_q;

            // Forward a and the remaining b slices alongside the accumulator.
            always_ff @(posedge clk) begin
               if (!reset) begin
                  a_q    <= '0;
                  brem_q <= '0;
               end else begin
                  a_q    <= a_in;
                  brem_q <= brem_in >> SLICE_W;
               end
            end
         end
      end

      assign result = g_stage[NUM_REGS].acc_q;
   end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Bench for pipelined_multiplier: directed scenarios on the default
// configuration plus a randomized sweep over several stage counts / widths,
// all checked against plain a*b arithmetic kept in the bench.
module tb_pipelined_multiplier;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;

   logic [31:0] a_s;
   logic [31:0] b_s;
   logic [31:0] res_p1;
   logic [31:0] res_p3;
   logic [15:0] res_w16_p4;
   logic [15:0] res_w16_p3;

   int tests_run;
   int tests_failed;

   // Default configuration: DATA_LEN=32, PIPELINE_STAGE=2 (latency 1).
   pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .result(result)
   );

   // Sweep instances driven by their own random operands.
   pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) dut_p1 (
      .clk(clk), .reset(reset), .a(a_s), .b(b_s), .result(res_p1)
   );
   pipelined_multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(3)) dut_p3 (
      .clk(clk), .reset(reset), .a(a_s), .b(b_s), .result(res_p3)
   );
   pipelined_multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(4)) dut_w16_p4 (
      .clk(clk), .reset(reset), .a(a_s[15:0]), .b(b_s[15:0]), .result(res_w16_p4)
   );
   pipelined_multiplier #(.DATA_LEN(16), .PIPELINE_STAGE(3)) dut_w16_p3 (
      .clk(clk), .reset(reset), .a(a_s[15:0]), .b(b_s[15:0]), .result(res_w16_p3)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: product of unsigned operands reduced to the given width.
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input int width);
      longint unsigned p;
      p = longint'(x) * longint'(y);
      if (width == 16) p = p & 64'h0000_0000_0000_FFFF;
      else             p = p & 64'h0000_0000_FFFF_FFFF;
      return 32'(p);
   endfunction

   // Driver: apply a pair at the falling edge, settle just after it.
   task automatic drive(input logic [31:0] aa, input logic [31:0] bb);
      @(negedge clk);
      a = aa;
      b = bb;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      a = 32'd7;
      b = 32'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         tests_run++;
         if (result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_hold cycle %0d: got %h want 0", i, result);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (result !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_release_before_capture: got %h want 0", result);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (result !== 32'd63) begin
         tests_failed++;
         $display("FAIL reset_first_result: got %0d want 63", result);
      end
   endtask

   task automatic test_latency();
      drive(32'd3, 32'd5);
      drive(32'd0, 32'd0);
      tests_run++;
      if (result !== 32'd15) begin
         tests_failed++;
         $display("FAIL latency_3x5: got %0d want 15", result);
      end
      drive(32'd0, 32'd0);
      tests_run++;
      if (result !== 32'd0) begin
         tests_failed++;
         $display("FAIL latency_zero: got %0d want 0", result);
      end
   endtask

   // Stream a list of pairs and check each result one cycle later.
   task automatic test_boundaries();
      logic [31:0] av[7];
      logic [31:0] bv[7];
      logic [31:0] exp_q[$];
      logic [31:0] expv;
      av = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'd1,
             32'd0,         32'h8000_0000, 32'hDEAD_BEEF};
      bv = '{32'd2,         32'h0001_0000, 32'hFFFF_FFFF, 32'hCAFE_F00D,
             32'h1234_5678, 32'd2,         32'd0};
      for (int i = 0; i <= 7; i++) begin
         if (i < 7) begin
            drive(av[i], bv[i]);
            exp_q.push_back(ref_mul(av[i], bv[i], 32));
         end else begin
            drive(32'd0, 32'd0);
         end
         if (i > 0) begin
            expv = exp_q.pop_front();
            tests_run++;
            if (result !== expv) begin
               tests_failed++;
               $display("FAIL boundary_%0d: got %h want %h", i - 1, result, expv);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] av[4];
      logic [31:0] bv[4];
      logic [31:0] want[4];
      av   = '{32'd2, 32'd4, 32'd6, 32'h1234_5678};
      bv   = '{32'd3, 32'd5, 32'd7, 32'h10};
      want = '{32'd6, 32'd20, 32'd42, 32'h2345_6780};
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) drive(av[i], bv[i]);
         else       drive(32'd0, 32'd0);
         if (i > 0) begin
            tests_run++;
            if (result !== want[i-1]) begin
               tests_failed++;
               $display("FAIL back_to_back_%0d: got %h want %h", i - 1, result, want[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      a = 32'd1000;
      b = 32'd1000;
      reset = 1'b0;
      @(negedge clk);
      #1;
      tests_run++;
      if (result !== 32'd0) begin
         tests_failed++;
         $display("FAIL midflight_flush: got %0d want 0", result);
      end
      reset = 1'b1;
      a = 32'd11;
      b = 32'd13;
      @(negedge clk);
      #1;
      tests_run++;
      if (result !== 32'd143) begin
         tests_failed++;
         $display("FAIL midflight_next: got %0d want 143", result);
      end
   endtask

   task automatic test_random_default();
      logic [31:0] exp_q[$];
      logic [31:0] expv;
      logic [31:0] ra;
      logic [31:0] rb;
      for (int i = 0; i <= 200; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         drive(ra, rb);
         exp_q.push_back(ref_mul(ra, rb, 32));
         if (i > 0) begin
            expv = exp_q.pop_front();
            tests_run++;
            if (result !== expv) begin
               tests_failed++;
               $display("FAIL random_default_%0d: got %h want %h", i - 1, result, expv);
            end
         end
      end
   endtask

   // Each sweep instance must show, after its own latency, the product of
   // the operands applied that many cycles earlier.
   task automatic test_param_sweep();
      logic [31:0] ha[$];
      logic [31:0] hb[$];
      logic [31:0] expv;
      int n;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a_s = $urandom;
         b_s = $urandom;
         ha.push_back(a_s);
         hb.push_back(b_s);
         #1;
         n = ha.size() - 1;
         expv = ref_mul(ha[n], hb[n], 32);
         tests_run++;
         if (res_p1 !== expv) begin
            tests_failed++;
            $display("FAIL sweep_w32_s1_%0d: got %h want %h", i, res_p1, expv);
         end
         if (n >= 2) begin
            expv = ref_mul(ha[n-2], hb[n-2], 32);
            tests_run++;
            if (res_p3 !== expv) begin
               tests_failed++;
               $display("FAIL sweep_w32_s3_%0d: got %h want %h", i, res_p3, expv);
            end
            expv = ref_mul(ha[n-2], hb[n-2], 16);
            tests_run++;
            if (res_w16_p3 !== expv[15:0]) begin
               tests_failed++;
               $display("FAIL sweep_w16_s3_%0d: got %h want %h", i, res_w16_p3, expv[15:0]);
            end
         end
         if (n >= 3) begin
            expv = ref_mul(ha[n-3], hb[n-3], 16);
            tests_run++;
            if (res_w16_p4 !== expv[15:0]) begin
               tests_failed++;
               $display("FAIL sweep_w16_s4_%0d: got %h want %h", i, res_w16_p4, expv[15:0]);
            end
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b0;
      a     = '0;
      b     = '0;
      a_s   = '0;
      b_s   = '0;
      test_reset();
      test_latency();
      test_boundaries();
      test_back_to_back();
      test_reset_midflight();
      test_random_default();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipelined_multiplier.md
Name: pipelined_multiplier

Overview:
- Unsigned DATA_LEN x DATA_LEN integer multiplier; returns the low DATA_LEN bits of the product.
- Pipelined with a configurable stage count; accepts a new operand pair every cycle, with no handshake.
- Sits in the AFU datapath. The host-side controller drives a/b from registers, waits a fixed number of cycles and samples result.

Parameters:
- DATA_LEN, 32, operand and result width in bits (>=2).
- PIPELINE_STAGE, 2, number of compute stages (>=1). The first stage is combinational from the inputs; each later stage ends in a register. Register latency = PIPELINE_STAGE-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset: pipeline cleared on a rising clk edge while reset==0.
- a  input  DATA_LEN  multiplicand, unsigned.
- b  input  DATA_LEN  multiplier, unsigned.
- result  output  DATA_LEN  (a*b) mod 2^DATA_LEN, registered when PIPELINE_STAGE>1.

Behaviour:
- Arithmetic:
  - result = low DATA_LEN bits of unsigned a*b; upper product bits are discarded (wrap-around).
  - No overflow flag.
- Decomposition:
  - b is split into PIPELINE_STAGE slices of ceil(DATA_LEN/PIPELINE_STAGE) bits; the last slice may be narrower.
  - Stage i adds the partial product a*slice_i, shifted by i*slice width, to a running DATA_LEN-bit accumulator.
  - a and the unused b slices travel with the accumulator through the pipeline.
- Latency:
  - a/b present before rising edge N appear on result after edge N+(PIPELINE_STAGE-2), i.e. PIPELINE_STAGE-1 register stages.
  - Default PIPELINE_STAGE=2: inputs changed just after edge T0 are captured at edge T1. result is valid after T1 and stable for sampling at edge T2.
  - PIPELINE_STAGE=1: purely combinational, result follows a/b in the same cycle; reset has no effect.
- Throughput: one operand pair per cycle; independent pairs flow back-to-back without interference.
- Holding: with constant a/b, result stays constant after the latency; no valid/ready signals.
- Reset:
  - While reset==0 at a rising edge, all pipeline registers (accumulators, forwarded operands) load 0. result = 0 from the following cycle.
  - Reset mid-operation discards all in-flight products. After reset returns to 1, the first new result appears exactly the normal latency after its inputs.
  - Inputs are ignored while reset==0.
- Boundaries:
  - a=0 or b=0 gives 0.
  - a=1 gives b.
  - Max operands give 1 (0xFFFFFFFF*0xFFFFFFFF mod 2^32).
  - Powers of two at or beyond 2^DATA_LEN give 0.
- No X propagation into result after reset. No latches; all registers on clk only.

Test Plan:
- Reset held low 3 cycles with a=7, b=9 -> result=0 throughout. Release, hold a=7, b=9 -> result=63 after 1 cycle (DATA_LEN=32, PIPELINE_STAGE=2).
- a=3, b=5 applied after edge T0, a=b=0 applied after edge T2 -> result=15 sampled at edge T2. result=0 one cycle after the zeroed operands are captured.
- Wrap-around: a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE. a=0x00010000, b=0x00010000 -> 0x00000000. a=b=0xFFFFFFFF -> 0x00000001.
- Back-to-back stream (2,3),(4,5),(6,7),(0x12345678,0x10) on consecutive cycles -> results 6, 20, 42, 0x23456780 on consecutive cycles, each 1 cycle after its inputs.
- Reset asserted for 1 cycle while (1000,1000) is in flight -> result 0 next cycle, product 1000000 never appears. Next pair (11,13) -> 143 at normal latency.
- Parameter sweep PIPELINE_STAGE=1,3,4 and DATA_LEN=16 with 1000 random pairs -> every result equals (a*b) mod 2^DATA_LEN at latency PIPELINE_STAGE-1.
